uart_core: RTL and testbench
============================

# uart_core

Parametrised UART engine: the next-generation serial block for the stopwatch/watch command path. Combines a programmable baud/oversample tick generator, an RX deserialiser with parity and framing checks, independent RX/TX FIFOs of configurable depth, and a TX serialiser. User logic talks to it through push/pop FIFO handshakes and sticky error flags. It replaces hard-wired echo plumbing with a host-side byte interface.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- BAUD, 9600: line bit rate.
- DATA_BITS, 8: payload bits per frame, legal 5..8.
- PARITY_MODE, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries per FIFO, power of two, 2..256.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- rx  input  1  serial line in, asynchronous to clk.
- tx  output  1  serial line out, idle high.
- tx_wdata  input  DATA_BITS  byte to transmit.
- tx_push  input  1  write tx_wdata into TX FIFO.
- tx_full  output  1  TX FIFO full.
- tx_count  output  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- tx_busy  output  1  serialiser not IDLE.
- rx_rdata  output  DATA_BITS  head of RX FIFO (first-word fall-through).
- rx_pop  input  1  consume head of RX FIFO.
- rx_empty  output  1  RX FIFO empty.
- rx_count  output  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- err_clr  input  1  clear all sticky error flags.
- parity_err, frame_err, overrun_err  output  1 each  sticky error flags.
- loopback  input  1  present only with UART_LOOPBACK_EN.

## Operation
- Tick gen: DIV = CLK_HZ/(BAUD*16) (integer truncation, DIV>=1). Counter 0..DIV-1; b_tick high exactly one clk when counter wraps. Free-running from reset.
- RX input: 2-flop synchroniser, both flops reset to 1.
- RX FSM: IDLE -> START on synchronised falling edge; START counts 8 ticks, line still 0 -> DATA, else back to IDLE (glitch reject). DATA samples every 16 ticks, LSB first, DATA_BITS samples. PARITY (if enabled) one sample. STOP samples STOP_BITS times, 16 ticks apart.
- Frame completion: any stop sample 0 -> frame_err set, byte discarded. Parity mismatch -> parity_err set, byte discarded. Good byte with RX FIFO full and no rx_pop that cycle -> byte dropped, overrun_err set. Otherwise pushed. FSM returns to IDLE after last stop sample (mid-stop), ready for next start edge.
- TX FSM: IDLE -> START when TX FIFO non-empty; head popped on that transition and latched in shift register. START (16 ticks, tx=0), DATA (DATA_BITS x 16 ticks, LSB first), PARITY (if enabled), STOP (STOP_BITS x 16 ticks, tx=1) -> IDLE. Back-to-back frames with no extra idle if FIFO non-empty.
- Parity: even = XOR of data bits; odd = inverted.
- FIFOs: push on full ignored (TX) / counted as overrun (RX); pop on empty ignored. Push+pop same cycle: when full both accepted, count unchanged; when empty push accepted, pop ignored. Pointers wrap modulo FIFO_DEPTH; count is exact 0..FIFO_DEPTH.
- Error flags: set on event, held until err_clr. Set and err_clr in same cycle -> flag stays set.

## Timing
- Reset (rst=0 at clk edge): tx=1, tx_busy=0, tx_full=0, rx_empty=1, counts 0, all error flags 0, rx_rdata 0, tick counter 0, both FSMs IDLE. Reset mid-frame aborts frame; tx returns high next cycle; FIFO contents lost.
- tx_push -> tx_count increments next cycle; tx falls no earlier than 1 clk after FIFO shows non-empty, aligned to next b_tick.
- tx_busy rises same cycle as tx goes low, falls after last stop-bit tick.
- RX byte visible on rx_rdata with rx_empty=0 one clk after final stop sample.
- rx_pop: rx_rdata/rx_count update next cycle.
- Error flag rises one clk after the failing sample.

## Configuration
- UART_LOOPBACK_EN defined: loopback port exists; loopback=1 feeds internal TX serial output into RX synchroniser input (external rx ignored) and holds pin tx high. loopback=0 normal.
- Undefined: no loopback port, no mux; rx pin always used.

## Test plan
- Reset: hold rst=0 3 clks -> tx=1, rx_empty=1, tx_count=0, all errs 0.
- CLK_HZ=1_600_000, BAUD=100_000, 8N1: push 0xA5 -> tx waveform 0,1,0,1,0,0,1,0,1,1 at 16 clks/bit, tx_busy high 160 clks.
- Drive rx 0x3C with even parity, 8E1 -> rx_rdata=0x3C, rx_count=1; same with parity bit flipped -> parity_err=1, rx_empty=1.
- Stop bit driven 0 -> frame_err=1, byte discarded; err_clr -> frame_err=0 next cycle.
- FIFO_DEPTH=4: receive 5 bytes 0x01..0x05 with no pop -> rx_count=4, overrun_err=1, pops yield 0x01..0x04.
- UART_LOOPBACK_EN, loopback=1: push 0x00,0xFF,0x5A -> received in order, pin tx stays 1 throughout.

Source files
------------

// File: rtl/uart_core.sv
// UART engine: baud tick generator, RX deserialiser with parity/framing checks,
// RX/TX FIFOs and TX serialiser. Optional internal loopback via UART_LOOPBACK_EN.
`timescale 1ns/1ps

module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk)
    if (rst && do_push) mem[wptr] <= wdata;
endmodule

module uart_core #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          tx,
  input  logic [DATA_BITS-1:0]          tx_wdata,
  input  logic                          tx_push,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_busy,
  output logic [DATA_BITS-1:0]          rx_rdata,
  input  logic                          rx_pop,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic                          err_clr,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun_err
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                          loopback
`endif
);
  localparam int   DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int   DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int   TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic HAS_PAR = (PARITY_MODE != 0);
  localparam logic ODD     = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Oversample tick, 16 per bit
  logic [TW-1:0] tick_cnt;
  logic          b_tick;
  assign b_tick = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)        tick_cnt <= '0;
    else if (b_tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  // TX path
  logic [DATA_BITS-1:0] txf_rdata;
  logic                 txf_empty, txf_pop;
  state_t               tx_state, tx_state_n;
  logic [3:0]           tx_tcnt;
  logic [2:0]           tx_bcnt;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_line, tx_bit_end;

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst(rst), .push(tx_push), .wdata(tx_wdata), .pop(txf_pop),
    .rdata(txf_rdata), .count(tx_count), .full(tx_full), .empty(txf_empty)
  );

  assign tx_bit_end = b_tick && (tx_tcnt == 4'd15);
  assign tx_busy    = (tx_state != IDLE);

  always_comb begin
    tx_state_n = tx_state;
    txf_pop    = 1'b0;
    tx_line    = 1'b1;
    case (tx_state)
      IDLE: if (b_tick && !txf_empty) begin
        tx_state_n = START;
        txf_pop    = 1'b1;
      end
      START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_n = DATA;
      end
      DATA: begin
        tx_line = tx_sh[0];
        if (tx_bit_end && tx_bcnt == 3'(DATA_BITS - 1))
          tx_state_n = HAS_PAR ? PAR : STOP;
      end
      PAR: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_state_n = STOP;
      end
      STOP: if (tx_bit_end && tx_bcnt == 3'(STOP_BITS - 1)) begin
        // Chain straight into the next frame when more data is queued
        if (!txf_empty) begin
          tx_state_n = START;
          txf_pop    = 1'b1;
        end else begin
          tx_state_n = IDLE;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_state_n != tx_state) begin
        tx_tcnt <= '0;
        tx_bcnt <= '0;
      end else if (b_tick && tx_state != IDLE) begin
        tx_tcnt <= tx_tcnt + 1'b1;
        if (tx_bit_end) tx_bcnt <= tx_bcnt + 1'b1;
      end
      if (txf_pop) begin
        tx_sh  <= txf_rdata;
        tx_par <= (^txf_rdata) ^ ODD;
      end else if (tx_bit_end && tx_state == DATA) begin
        tx_sh <= tx_sh >> 1;
      end
    end
  end

  // RX input select and synchroniser
  logic rx_in, rx_m, rx_s, rx_d;
`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line : rx;
  assign tx    = loopback | tx_line;
`else
  assign rx_in = rx;
  assign tx    = tx_line;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // RX deserialiser
  state_t               rx_state, rx_state_n;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_bcnt;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_ferr, rx_perr;
  logic                 smp_start, smp, rx_done, par_bad;
  logic                 rx_push, parity_set, frame_set, overrun_set;

  assign smp_start = b_tick && (rx_tcnt == 4'd7);
  assign smp       = b_tick && (rx_tcnt == 4'd15);
  assign par_bad   = (rx_s != ((^rx_sh) ^ ODD));

  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      IDLE:  if (rx_d && !rx_s) rx_state_n = START;
      START: if (smp_start) rx_state_n = rx_s ? IDLE : DATA;
      DATA:  if (smp && rx_bcnt == 3'(DATA_BITS - 1)) rx_state_n = HAS_PAR ? PAR : STOP;
      PAR:   if (smp) rx_state_n = STOP;
      STOP:  if (smp && rx_bcnt == 3'(STOP_BITS - 1)) rx_state_n = IDLE;
      default: rx_state_n = IDLE;
    endcase
  end

  assign rx_done     = (rx_state == STOP) && smp && (rx_bcnt == 3'(STOP_BITS - 1));
  assign frame_set   = (rx_state == STOP) && smp && !rx_s;
  assign parity_set  = (rx_state == PAR) && smp && par_bad;
  assign rx_push     = rx_done && !rx_ferr && rx_s && !rx_perr;
  assign overrun_set = rx_push && (rx_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH)) && !rx_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_sh    <= '0;
      rx_ferr  <= 1'b0;
      rx_perr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      if (rx_state_n != rx_state) begin
        rx_tcnt <= '0;
        rx_bcnt <= '0;
      end else if (b_tick && rx_state != IDLE) begin
        rx_tcnt <= rx_tcnt + 1'b1;
        if (smp) rx_bcnt <= rx_bcnt + 1'b1;
      end
      if (rx_state == START && rx_state_n == DATA) begin
        rx_ferr <= 1'b0;
        rx_perr <= 1'b0;
      end
      if (smp && rx_state == DATA) rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
      if (parity_set) rx_perr <= 1'b1;
      if (frame_set)  rx_ferr <= 1'b1;
    end
  end

  uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_sh), .pop(rx_pop),
    .rdata(rx_rdata), .count(rx_count), .full(), .empty(rx_empty)
  );

  // Sticky flags: a set event outranks err_clr
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      parity_err  <= parity_set  | (parity_err  & ~err_clr);
      frame_err   <= frame_set   | (frame_err   & ~err_clr);
      overrun_err <= overrun_set | (overrun_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: u0 is 8N1 (TX path, loopback), u1 is 8E1 with a 4-deep FIFO (RX path).
`timescale 1ns/1ps

module tb_uart_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       rx0 = 1'b1, tx0, push0 = 1'b0, full0, busy0, pop0 = 1'b0, empty0, clr0 = 1'b0;
  logic       pe0, fe0, oe0;
  logic [7:0] wd0 = '0, rd0;
  logic [4:0] tcnt0, rcnt0;
  logic       rx1 = 1'b1, tx1, push1 = 1'b0, full1, busy1, pop1 = 1'b0, empty1, clr1 = 1'b0;
  logic       pe1, fe1, oe1;
  logic [7:0] wd1 = '0, rd1;
  logic [2:0] tcnt1, rcnt1;
`ifdef UART_LOOPBACK_EN
  logic lb0 = 1'b0, lb1 = 1'b0;
`endif

  uart_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_MODE(0),
              .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .tx(tx0), .tx_wdata(wd0), .tx_push(push0),
    .tx_full(full0), .tx_count(tcnt0), .tx_busy(busy0), .rx_rdata(rd0), .rx_pop(pop0),
    .rx_empty(empty0), .rx_count(rcnt0), .err_clr(clr0), .parity_err(pe0),
    .frame_err(fe0), .overrun_err(oe0)
`ifdef UART_LOOPBACK_EN
    , .loopback(lb0)
`endif
  );

  uart_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_MODE(1),
              .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .tx(tx1), .tx_wdata(wd1), .tx_push(push1),
    .tx_full(full1), .tx_count(tcnt1), .tx_busy(busy1), .rx_rdata(rd1), .rx_pop(pop1),
    .rx_empty(empty1), .rx_count(rcnt1), .err_clr(clr1), .parity_err(pe1),
    .frame_err(fe1), .overrun_err(oe1)
`ifdef UART_LOOPBACK_EN
    , .loopback(lb1)
`endif
  );

  int errs = 0, checks = 0;
  logic [7:0] txq[$], rxq0[$], rxq1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // on_pin=1: frame expected on tx pin; else expected back through loopback RX
  task automatic push_tx(input logic [7:0] d, input bit on_pin);
    @(posedge clk); #1 wd0 = d; push0 = 1'b1;
    if (on_pin) txq.push_back(d); else rxq0.push_back(d);
    @(posedge clk); #1 push0 = 1'b0;
  endtask

  task automatic pop_rx(input int u);
    @(posedge clk); #1 if (u == 0) pop0 = 1'b1; else pop1 = 1'b1;
    @(posedge clk); #1 pop0 = 1'b0; pop1 = 1'b0;
  endtask

  task automatic err_clear();
    @(posedge clk); #1 clr1 = 1'b1;
    @(posedge clk); #1 clr1 = 1'b0;
  endtask

  // 8E1 frame into u1, 16 clks per bit
  task automatic send1(input logic [7:0] d, input logic pflip, input logic stop);
    logic [10:0] f;
    f = {stop, (^d) ^ pflip, d, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) begin
      rx1 = f[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx1 = 1'b1;
    repeat (24) @(posedge clk);
    #1;
  endtask

  // RX scoreboards: compare head whenever a pop is accepted
  always @(negedge clk) begin
    if (pop1 && !empty1) begin
      if (rxq1.size() == 0) begin
        checks++; errs++;
        $display("FAIL rx1_unexpected: got %0h want none", rd1);
      end else chk("rx1_data", rd1, rxq1.pop_front());
    end
    if (pop0 && !empty0) begin
      if (rxq0.size() == 0) begin
        checks++; errs++;
        $display("FAIL rx0_unexpected: got %0h want none", rd0);
      end else chk("rx0_data", rd0, rxq0.pop_front());
    end
  end

  // TX line monitor: decode 8N1 frames at mid-bit
  initial begin : txmon
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge clk);
      if (rst && tx0 === 1'b0) begin
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx0;
        end
        repeat (16) @(negedge clk);
        stp = tx0;
        if (txq.size() == 0) begin
          checks++; errs++;
          $display("FAIL tx_unexpected: got %0h want none", b);
        end else chk("tx_frame", {stp, b}, {1'b1, txq.pop_front()});
      end
    end
  end

  initial begin
    #1ms;
    errs++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

  initial begin
    logic [9:0] w;
    int n, busy_cnt, lows;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_txfull", full0, 0);
    chk("rst_txcount", tcnt0, 0);
    chk("rst_rxempty", empty1, 1);
    chk("rst_rxcount", rcnt1, 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_errs", {pe1, fe1, oe1}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // TX waveform of 0xA5
    push_tx(8'hA5, 1'b1);
    @(negedge clk);
    chk("tx_count_inc", tcnt0, 1);
    n = 0;
    while (tx0 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("tx_start_seen", tx0, 0);
    w = {1'b1, 8'hA5, 1'b0};
    busy_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      if (busy0) busy_cnt++;
      if (i % 16 == 8) chk("tx_bit", tx0, w[i/16]);
    end
    @(negedge clk);
    chk("tx_busy_end", busy0, 0);
    chk("tx_busy_len", busy_cnt, 160);

    // Back-to-back frames
    push_tx(8'h3C, 1'b1);
    push_tx(8'hC3, 1'b1);
    repeat (400) @(negedge clk);
    chk("tx_drained", tcnt0, 0);
    chk("tx_idle", busy0, 0);
    chk("txq_empty", txq.size(), 0);

    // RX good byte, 8E1
    send1(8'h3C, 1'b0, 1'b1);
    rxq1.push_back(8'h3C);
    chk("rx_count1", rcnt1, 1);
    chk("rx_nonempty", empty1, 0);
    chk("rx_no_perr", pe1, 0);
    pop_rx(1);
    chk("rx_count_pop", rcnt1, 0);
    chk("rx_empty_pop", empty1, 1);

    // Parity error
    send1(8'h3C, 1'b1, 1'b1);
    chk("perr_set", pe1, 1);
    chk("perr_discard", empty1, 1);
    chk("perr_nofe", fe1, 0);
    err_clear();
    chk("perr_clr", pe1, 0);

    // Framing error
    send1(8'h55, 1'b0, 1'b0);
    chk("ferr_set", fe1, 1);
    chk("ferr_discard", empty1, 1);
    err_clear();
    chk("ferr_clr", fe1, 0);

    // Overrun on 4-deep FIFO
    for (int d = 1; d <= 5; d++) send1(8'(d), 1'b0, 1'b1);
    for (int d = 1; d <= 4; d++) rxq1.push_back(8'(d));
    chk("ovr_count", rcnt1, 4);
    chk("ovr_set", oe1, 1);
    chk("ovr_noother", {pe1, fe1}, 0);
    repeat (4) pop_rx(1);
    chk("ovr_drained", empty1, 1);
    chk("rxq1_empty", rxq1.size(), 0);

`ifdef UART_LOOPBACK_EN
    @(posedge clk); #1 lb0 = 1'b1;
    push_tx(8'h00, 1'b0);
    push_tx(8'hFF, 1'b0);
    push_tx(8'h5A, 1'b0);
    lows = 0;
    repeat (600) begin @(negedge clk); if (tx0 !== 1'b1) lows++; end
    chk("lb_pin_high", lows, 0);
    chk("lb_rx_count", rcnt0, 3);
    repeat (3) pop_rx(0);
    chk("lb_rx_empty", empty0, 1);
    chk("rxq0_empty", rxq0.size(), 0);
    @(posedge clk); #1 lb0 = 1'b0;
`else
    lows = 0;
`endif

    chk("u0_errs", {pe0, fe0, oe0}, 0);
    chk("u1_tx_idle", {tx1, busy1, full1, tcnt1}, {1'b1, 1'b0, 1'b0, 3'd0});
    chk("u0_rx_idle", {empty0, rcnt0, rd0}, {1'b1, 5'd0, 8'd0});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
